// File: rtl/reg_file_lq.sv
// Register file with bypassed read ports and a pending-load return queue.
// Busy scoreboard over queued load destinations drives the Stall output.
module reg_file_lq #(
  parameter int W         = 8,
  parameter int D         = 3,
  parameter int FIXED_REG = 1,
  parameter int LQ_DEPTH  = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        REG_WRITE,
  input  logic [1:0]        WD_SRC,
  input  logic [D-1:0]      RS_addr,
  input  logic [D-1:0]      RT_addr,
  input  logic [W-1:0]      Imm,
  input  logic [W-1:0]      mem_data,
  input  logic [W-1:0]      ALU_result,
  input  logic              Load_Issue,
  input  logic [D-1:0]      Load_Dst,
  input  logic              Load_Done,
  output logic [W-1:0]      DataOut_RS,
  output logic [W-1:0]      DataOut_RT,
  output logic [W-1:0]      DataOut_R0,
  output logic [W-1:0]      DataOut_R1,
  output logic              Stall,
  output logic              Load_Full,
  output logic [(2**D)-1:0] Busy_Vec
);

  localparam int NR = 2 ** D;
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  regs_q [NR];
  logic [W-1:0]  regs_d [NR];
  logic [D-1:0]  lq_q   [LQ_DEPTH];
  logic [D-1:0]  lq_d   [LQ_DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  r0_q, r1_q;

  logic [D-1:0]  a_dst;
  logic [W-1:0]  a_data;
  logic          a_we;
  logic [D-1:0]  b_dst;
  logic          pop;
  logic          push;
  logic          full;
  logic          stall;
  logic [NR-1:0] busy;
  logic [AW-1:0] off;

  always_comb begin
    a_dst = RT_addr;
    unique case (REG_WRITE)
      2'b01:   a_dst = RT_addr;
      2'b10:   a_dst = D'(FIXED_REG);
      2'b11:   a_dst = RS_addr;
      default: a_dst = RT_addr;
    endcase
  end

  always_comb begin
    a_data = Imm;
    unique case (WD_SRC)
      2'b00:   a_data = Imm;
      2'b01:   a_data = mem_data;
      2'b10:   a_data = ALU_result;
      default: a_data = Imm;
    endcase
  end

  assign full  = (cnt_q == CW'(LQ_DEPTH));
  assign pop   = Load_Done && (cnt_q != '0);
  assign b_dst = lq_q[head_q];

  // The completing head no longer blocks, so its consumer issues this cycle.
  always_comb begin
    busy = '0;
    off  = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off = AW'(i) - head_q;
      if (({1'b0, off} < cnt_q) && !(pop && (AW'(i) == head_q)))
        busy[lq_q[i]] = 1'b1;
    end
  end

  assign stall = busy[RS_addr] | busy[RT_addr]
               | ((REG_WRITE != 2'b00) & busy[a_dst]);

  assign a_we = (REG_WRITE != 2'b00) && (WD_SRC != 2'b11) && !stall;
  assign push = Load_Issue && !stall && (!full || pop);

  // Port A is the younger write, so it is applied last and wins.
  always_comb begin
    regs_d = regs_q;
    if (pop)
      regs_d[b_dst] = mem_data;
    if (a_we)
      regs_d[a_dst] = a_data;
  end

  always_comb begin
    lq_d = lq_q;
    if (push)
      lq_d[tail_q] = Load_Dst;
  end

  assign head_d = head_q + AW'(pop);
  assign tail_d = tail_q + AW'(push);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    if (a_we && (a_dst == RS_addr))
      DataOut_RS = a_data;
    else if (pop && (b_dst == RS_addr))
      DataOut_RS = mem_data;
    else
      DataOut_RS = regs_q[RS_addr];
  end

  always_comb begin
    if (a_we && (a_dst == RT_addr))
      DataOut_RT = a_data;
    else if (pop && (b_dst == RT_addr))
      DataOut_RT = mem_data;
    else
      DataOut_RT = regs_q[RT_addr];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      regs_q <= '{default: '0};
      lq_q   <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      r0_q   <= '0;
      r1_q   <= '0;
    end else begin
      regs_q <= regs_d;
      lq_q   <= lq_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      r0_q   <= regs_d[0];
      r1_q   <= regs_d[1];
    end
  end

  assign DataOut_R0 = r0_q;
  assign DataOut_R1 = r1_q;
  assign Stall      = stall;
  assign Load_Full  = full;
  assign Busy_Vec   = busy;

endmodule

// File: tb/tb_reg_file_lq.sv
// Directed bench for reg_file_lq: per-cycle vector table plus
// hand-written reset-with-pending-loads sequences.
module tb_reg_file_lq;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [1:0] REG_WRITE, WD_SRC;
  logic [2:0] RS_addr, RT_addr, Load_Dst;
  logic [7:0] Imm, mem_data, ALU_result;
  logic       Load_Issue, Load_Done;
  logic [7:0] DataOut_RS, DataOut_RT, DataOut_R0, DataOut_R1;
  logic       Stall, Load_Full;
  logic [7:0] Busy_Vec;

  int total = 0;
  int bad   = 0;

  reg_file_lq dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .REG_WRITE(REG_WRITE), .WD_SRC(WD_SRC),
    .RS_addr(RS_addr), .RT_addr(RT_addr),
    .Imm(Imm), .mem_data(mem_data), .ALU_result(ALU_result),
    .Load_Issue(Load_Issue), .Load_Dst(Load_Dst), .Load_Done(Load_Done),
    .DataOut_RS(DataOut_RS), .DataOut_RT(DataOut_RT),
    .DataOut_R0(DataOut_R0), .DataOut_R1(DataOut_R1),
    .Stall(Stall), .Load_Full(Load_Full), .Busy_Vec(Busy_Vec)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] rw, ws;
    logic [2:0] rs, rt;
    logic [7:0] imm, mem, alu;
    logic       li;
    logic [2:0] ldst;
    logic       ld;
    logic [7:0] ers, ert, er0, er1;
    logic       est, efull;
    logic [7:0] ebusy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic [1:0] rw, logic [1:0] ws, logic [2:0] rs, logic [2:0] rt,
    logic [7:0] imm, logic [7:0] mem, logic [7:0] alu,
    logic li, logic [2:0] ldst, logic ld,
    logic [7:0] ers, logic [7:0] ert, logic [7:0] er0, logic [7:0] er1,
    logic est, logic efull, logic [7:0] ebusy);
    vec_t v;
    v.rw = rw; v.ws = ws; v.rs = rs; v.rt = rt;
    v.imm = imm; v.mem = mem; v.alu = alu;
    v.li = li; v.ldst = ldst; v.ld = ld;
    v.ers = ers; v.ert = ert; v.er0 = er0; v.er1 = er1;
    v.est = est; v.efull = efull; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] rw, logic [1:0] ws,
                       logic [2:0] rs, logic [2:0] rt,
                       logic [7:0] imm, logic [7:0] mem, logic [7:0] alu,
                       logic li, logic [2:0] ldst, logic ld);
    REG_WRITE = rw; WD_SRC = ws; RS_addr = rs; RT_addr = rt;
    Imm = imm; mem_data = mem; ALU_result = alu;
    Load_Issue = li; Load_Dst = ldst; Load_Done = ld;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    // rows: rw ws rs rt imm mem alu li ldst ld | rs rt r0 r1 stall full busy
    vq.push_back(mk(0,0,0,1,8'h00,8'h00,8'h00,0,0,0, 8'h00,8'h00,8'h00,8'h00,0,0,8'h00));
    vq.push_back(mk(1,0,0,3,8'h5A,8'h00,8'h00,0,0,0, 8'h00,8'h5A,8'h00,8'h00,0,0,8'h00));
    vq.push_back(mk(0,0,3,0,8'h00,8'h00,8'h00,0,0,0, 8'h5A,8'h00,8'h00,8'h00,0,0,8'h00));
    vq.push_back(mk(2,2,1,3,8'h00,8'h00,8'hC3,0,0,0, 8'hC3,8'h5A,8'h00,8'h00,0,0,8'h00));
    vq.push_back(mk(3,3,1,3,8'hFF,8'hEE,8'hDD,0,0,0, 8'hC3,8'h5A,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,1,3,8'h00,8'h00,8'h00,0,0,0, 8'hC3,8'h5A,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,4,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(1,0,4,0,8'h99,8'h00,8'h00,0,0,0, 8'h00,8'h00,8'h00,8'hC3,1,0,8'h10));
    vq.push_back(mk(0,0,4,0,8'h00,8'h77,8'h00,0,0,1, 8'h77,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,4,0,8'h00,8'h00,8'h00,0,0,0, 8'h77,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,2,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,5,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h04));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,6,0, 8'h00,8'h00,8'h00,8'hC3,0,1,8'h24));
    vq.push_back(mk(0,0,2,5,8'h00,8'h11,8'h00,0,0,1, 8'h11,8'h00,8'h00,8'hC3,1,1,8'h20));
    vq.push_back(mk(0,0,2,5,8'h00,8'h22,8'h00,0,0,1, 8'h11,8'h22,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,2,5,8'h00,8'h00,8'h00,0,0,0, 8'h11,8'h22,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,2,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,5,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h04));
    vq.push_back(mk(0,0,0,0,8'h00,8'h33,8'h00,1,6,1, 8'h00,8'h00,8'h00,8'hC3,0,1,8'h20));
    vq.push_back(mk(0,0,2,6,8'h00,8'h00,8'h00,0,0,0, 8'h33,8'h00,8'h00,8'hC3,1,1,8'h60));
    vq.push_back(mk(0,0,5,6,8'h00,8'h44,8'h00,0,0,1, 8'h44,8'h00,8'h00,8'hC3,1,1,8'h40));
    vq.push_back(mk(0,0,6,5,8'h00,8'h55,8'h00,0,0,1, 8'h55,8'h44,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,6,5,8'h00,8'hAA,8'h00,0,0,1, 8'h55,8'h44,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,6,5,8'h00,8'h00,8'h00,0,0,0, 8'h55,8'h44,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,0,8'h00,8'h00,8'h00,1,7,0, 8'h00,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(1,0,7,7,8'h12,8'hBB,8'h00,0,0,1, 8'h12,8'h12,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,7,0,8'h00,8'h00,8'h00,0,0,0, 8'h12,8'h00,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(3,1,0,1,8'h00,8'h3C,8'h00,0,0,0, 8'h3C,8'hC3,8'h00,8'hC3,0,0,8'h00));
    vq.push_back(mk(0,0,0,1,8'h00,8'h00,8'h00,0,0,0, 8'h3C,8'hC3,8'h3C,8'hC3,0,0,8'h00));

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    foreach (vq[i]) begin
      if (i != 0) @(negedge Clk);
      drive(vq[i].rw, vq[i].ws, vq[i].rs, vq[i].rt, vq[i].imm,
            vq[i].mem, vq[i].alu, vq[i].li, vq[i].ldst, vq[i].ld);
      #2;
      chk($sformatf("v%0d rs", i), 32'(DataOut_RS), 32'(vq[i].ers));
      chk($sformatf("v%0d rt", i), 32'(DataOut_RT), 32'(vq[i].ert));
      chk($sformatf("v%0d r0", i), 32'(DataOut_R0), 32'(vq[i].er0));
      chk($sformatf("v%0d r1", i), 32'(DataOut_R1), 32'(vq[i].er1));
      chk($sformatf("v%0d stall", i), 32'(Stall), 32'(vq[i].est));
      chk($sformatf("v%0d full", i), 32'(Load_Full), 32'(vq[i].efull));
      chk($sformatf("v%0d busy", i), 32'(Busy_Vec), 32'(vq[i].ebusy));
    end

    // reset with one load pending to reg2 (reg2 currently holds 33)
    @(negedge Clk);
    drive(2'b00, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0);
    @(negedge Clk);
    idle();
    RS_addr = 3'd2;
    #2;
    chk("pend busy", 32'(Busy_Vec), 32'h04);
    chk("pend stall", 32'(Stall), 32'h1);
    chk("pend rs", 32'(DataOut_RS), 32'h33);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    RS_addr = 3'd2;
    RT_addr = 3'd1;
    #2;
    chk("rst busy", 32'(Busy_Vec), 32'h00);
    chk("rst stall", 32'(Stall), 32'h0);
    chk("rst full", 32'(Load_Full), 32'h0);
    chk("rst rs", 32'(DataOut_RS), 32'h00);
    chk("rst rt", 32'(DataOut_RT), 32'h00);
    chk("rst r0", 32'(DataOut_R0), 32'h00);
    chk("rst r1", 32'(DataOut_R1), 32'h00);
    Load_Done = 1'b1;
    mem_data = 8'h99;
    #1;
    chk("rst ld byp", 32'(DataOut_RS), 32'h00);
    @(negedge Clk);
    idle();
    RS_addr = 3'd2;
    #2;
    chk("rst ld nowr", 32'(DataOut_RS), 32'h00);

    // reset clears a full queue
    @(negedge Clk);
    drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0);
    @(negedge Clk);
    Load_Dst = 3'd5;
    @(negedge Clk);
    idle();
    #2;
    chk("full2 full", 32'(Load_Full), 32'h1);
    chk("full2 busy", 32'(Busy_Vec), 32'h24);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    #2;
    chk("rst2 full", 32'(Load_Full), 32'h0);
    chk("rst2 busy", 32'(Busy_Vec), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
